nonconsec_seq_gen: RTL

NONCONSEC_SEQ_GEN -- requirements
Module: nonconsec_seq_gen

---
 rtl/nonconsec_seq_gen_if.sv | 29 ++
 rtl/nonconsec_seq_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/nonconsec_seq_gen_if.sv
// nonconsec_seq_gen_if -- request/pulse bundle for the non-consecutive
// sequence generator.
//   start      : sequence request from the requester
//   gap, tail  : spacing values, captured when start is accepted
//   a, b, c    : antecedent, repetition and terminating pulses
//   busy, done : sequence in progress / one-cycle completion strobe
//   err        : sticky "start was ignored" flag (only with SEQGEN_ERR_EN)
// Modports: master = requester side, slave = generator side.
interface nonconsec_seq_gen_if #(
  parameter int GAP_W = 4
);
  logic             start;
  logic [GAP_W-1:0] gap;
  logic [GAP_W-1:0] tail;
  logic             a;
  logic             b;
  logic             c;
  logic             busy;
  logic             done;
`ifdef SEQGEN_ERR_EN
  logic             err;

  modport master (output start, gap, tail, input a, b, c, busy, done, err);
  modport slave  (input start, gap, tail, output a, b, c, busy, done, err);
`else
  modport master (output start, gap, tail, input a, b, c, busy, done);
  modport slave  (input start, gap, tail, output a, b, c, busy, done);
`endif
endinterface

// File: rtl/nonconsec_seq_gen.sv
// nonconsec_seq_gen -- emits, per accepted start, one a pulse, then B_COUNT
// b pulses spaced by 'gap' idle cycles (also gap idle cycles before the first
// b), then 'tail' idle cycles, then one c pulse (with done).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : nonconsec_seq_gen_if.slave (start/gap/tail in; a/b/c/busy/done out)
// Optional macro SEQGEN_ERR_EN adds bus.err, a sticky flag set when a start
// arrives while the generator cannot accept it (cleared only by rst).
// Outputs are flops loaded from the next state, so start has no
// combinational path to any output.
module nonconsec_seq_gen #(
  parameter int B_COUNT = 3,
  parameter int GAP_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  nonconsec_seq_gen_if.slave   bus
);

  localparam int               BC_W   = $clog2(B_COUNT + 1);
  localparam logic [BC_W-1:0]  B_LAST = BC_W'(B_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE, A_PH, GAP, B_PH, TAIL, C_PH
  } state_t;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] tail_q, tail_d;
  logic [GAP_W-1:0] cnt_q, cnt_d;
  logic [BC_W-1:0]  bcnt_q, bcnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SEQGEN_ERR_EN
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
`ifdef SEQGEN_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      // IDLE and C_PH are the only states that accept a request; from C_PH
      // this gives a back-to-back sequence with busy held high.
      IDLE, C_PH: begin
        if (bus.start) begin
          state_d = A_PH;
          gap_d   = bus.gap;
          tail_d  = bus.tail;
          bcnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      A_PH: begin
        if (gap_q == '0) begin
          state_d = B_PH;
        end else begin
          state_d = GAP;
          cnt_d   = gap_q - GAP_W'(1);
        end
      end
      // cnt holds the idle cycles still to go after the current one; a
      // down-count from the captured value cannot wrap, even at all-ones.
      GAP: begin
        if (cnt_q == '0) state_d = B_PH;
        else             cnt_d   = cnt_q - GAP_W'(1);
      end
      B_PH: begin
        if (bcnt_q == B_LAST) begin
          bcnt_d = '0;
          if (tail_q == '0) begin
            state_d = C_PH;
          end else begin
            state_d = TAIL;
            cnt_d   = tail_q - GAP_W'(1);
          end
        end else begin
          bcnt_d = bcnt_q + BC_W'(1);
          if (gap_q == '0) begin
            state_d = B_PH;
          end else begin
            state_d = GAP;
            cnt_d   = gap_q - GAP_W'(1);
          end
        end
      end
      TAIL: begin
        if (cnt_q == '0) state_d = C_PH;
        else             cnt_d   = cnt_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

`ifdef SEQGEN_ERR_EN
    if (bus.start && (state_q == A_PH || state_q == GAP ||
                      state_q == B_PH || state_q == TAIL))
      err_d = 1'b1;
`endif

    a_d    = (state_d == A_PH);
    b_d    = (state_d == B_PH);
    c_d    = (state_d == C_PH);
    done_d = (state_d == C_PH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQGEN_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQGEN_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.a    = a_q;
  assign bus.b    = b_q;
  assign bus.c    = c_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef SEQGEN_ERR_EN
  assign bus.err  = err_q;
`endif

endmodule
